// File: rtl/midi_parser_if.sv
// Shared constants and the byte-in / event-out bus of the MIDI parser.
package midi_parser_pkg;
  localparam int MIDI_BYTES = 24;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_D1 = 2'd1,
    ST_WAIT_D2 = 2'd2,
    ST_SYSEX   = 2'd3
  } parser_state_t;
endpackage

// Bytes flow from the UART side (master) into the parser (slave).
// byte_valid_in is a one-cycle strobe per byte; there is no back-pressure.
// event_valid_out is a one-cycle pulse marking each new midi_event_out.
interface midi_parser_if;
  import midi_parser_pkg::*;

  logic [7:0]            byte_in;
  logic                  byte_valid_in;
  logic [MIDI_BYTES-1:0] midi_event_out;
  logic                  event_valid_out;
  logic [7:0]            drop_count_out;
  parser_state_t         parser_state;

  modport master (
    output byte_in, byte_valid_in,
    input  midi_event_out, event_valid_out, drop_count_out, parser_state
  );

  modport slave (
    input  byte_in, byte_valid_in,
    output midi_event_out, event_valid_out, drop_count_out, parser_state
  );
endinterface

// File: rtl/midi_parser.sv
// MIDI byte-stream parser: assembles channel-voice messages with running
// status, skips realtime/SysEx/system-common bytes, filters by channel and
// normalises NOTE_ON velocity 0 into NOTE_OFF.
module midi_parser
  import midi_parser_pkg::*;
#(
  parameter int CHANNEL = 0,
  parameter bit OMNI    = 1'b1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  midi_parser_if.slave  bus
);

  localparam logic [3:0] CHAN_NIB = 4'(CHANNEL);

  parser_state_t         r_state;
  parser_state_t         w_state_nxt;
  logic [7:0]            r_status;
  logic [7:0]            r_d1;
  logic [MIDI_BYTES-1:0] r_event;
  logic                  r_event_valid;
  logic [7:0]            r_drop;

  logic       w_is_data;
  logic       w_is_chan;
  logic       w_is_sysex;
  logic       w_is_common;
  logic       w_two_byte;
  logic       w_chan_ok;
  logic [7:0] w_status_nxt;
  logic [7:0] w_d1_nxt;
  logic [7:0] w_ev_d1;
  logic [7:0] w_ev_d2;
  logic       w_accept;
  logic       w_emit;
  logic       w_drop;
  logic [MIDI_BYTES-1:0] w_event_nxt;

  // Byte classification; realtime F8-FF matches none of these and is a no-op.
  always_comb begin
    w_is_data   = ~bus.byte_in[7];
    w_is_chan   = bus.byte_in[7] && (bus.byte_in[7:4] != 4'hF);
    w_is_sysex  = (bus.byte_in == 8'hF0);
    w_is_common = (bus.byte_in[7:3] == 5'b11110) && (bus.byte_in != 8'hF0);
    w_two_byte  = (r_status[7:4] == 4'hC) || (r_status[7:4] == 4'hD);
    w_chan_ok   = OMNI || (r_status[3:0] == CHAN_NIB);
  end

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: any status byte (except realtime) overrides the current state,
  // which also covers aborting a partial message and leaving SysEx.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.byte_valid_in) begin
      if (w_is_chan) begin
        w_state_nxt = ST_WAIT_D1;
      end else if (w_is_sysex) begin
        w_state_nxt = ST_SYSEX;
      end else if (w_is_common) begin
        w_state_nxt = ST_IDLE;
      end else if (w_is_data) begin
        case (r_state)
          ST_WAIT_D1: if (!w_two_byte) w_state_nxt = ST_WAIT_D2;
          ST_WAIT_D2: w_state_nxt = ST_WAIT_D1;
          default:    w_state_nxt = r_state;
        endcase
      end
    end
  end

  // Outputs of the FSM: running-status/d1 updates, completion and drop flags.
  always_comb begin
    w_status_nxt = r_status;
    w_d1_nxt     = r_d1;
    w_ev_d1      = r_d1;
    w_ev_d2      = 8'h00;
    w_accept     = 1'b0;
    w_drop       = 1'b0;
    if (bus.byte_valid_in) begin
      if (w_is_chan) begin
        w_status_nxt = bus.byte_in;
      end else if (w_is_sysex || w_is_common) begin
        w_status_nxt = 8'h00;
      end else if (w_is_data) begin
        case (r_state)
          ST_IDLE: w_drop = 1'b1;
          ST_WAIT_D1: begin
            w_d1_nxt = bus.byte_in;
            w_ev_d1  = bus.byte_in;
            w_accept = w_two_byte;
          end
          ST_WAIT_D2: begin
            w_ev_d2  = bus.byte_in;
            w_accept = 1'b1;
          end
          default: ;
        endcase
      end
    end
    w_emit = w_accept && w_chan_ok;
    // Channel nibble is always zeroed; NOTE_ON with velocity 0 becomes NOTE_OFF.
    if ((r_status[7:4] == 4'h9) && (w_ev_d2 == 8'h00))
      w_event_nxt = {8'h80, w_ev_d1, 8'h00};
    else
      w_event_nxt = {r_status[7:4], 4'h0, w_ev_d1, w_ev_d2};
  end

  // Datapath registers: running status, first data byte, event bus and drop counter.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_status      <= 8'h00;
      r_d1          <= 8'h00;
      r_event       <= '0;
      r_event_valid <= 1'b0;
      r_drop        <= 8'h00;
    end else begin
      r_status      <= w_status_nxt;
      r_d1          <= w_d1_nxt;
      r_event_valid <= w_emit;
      if (w_emit) r_event <= w_event_nxt;
      if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
    end
  end

  assign bus.midi_event_out  = r_event;
  assign bus.event_valid_out = r_event_valid;
  assign bus.drop_count_out  = r_drop;
  assign bus.parser_state    = r_state;

endmodule

// File: tb/tb_midi_parser.sv
// Bench for midi_parser: an omni instance and a channel-0-only instance fed
// the same byte stream, checked against a message-level reference model.
module tb_midi_parser;
  import midi_parser_pkg::*;

  logic clk;
  logic rst;

  midi_parser_if bus_a ();
  midi_parser_if bus_f ();

  midi_parser #(.CHANNEL(0), .OMNI(1'b1)) u_dut_omni (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus_a.slave)
  );

  midi_parser #(.CHANNEL(0), .OMNI(1'b0)) u_dut_filt (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus_f.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: message-level view of the stream.
  logic [7:0]  m_status;
  bit          m_in_sysex;
  logic [7:0]  m_pend[$];
  int          m_drops;
  logic [23:0] exp_q0[$];
  logic [23:0] exp_q1[$];
  logic [23:0] m_last0;
  logic [23:0] m_last1;
  logic [7:0]  seq[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_status   = 8'h00;
    m_in_sysex = 1'b0;
    m_pend.delete();
    m_drops    = 0;
    exp_q0.delete();
    exp_q1.delete();
    m_last0    = '0;
    m_last1    = '0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int          need;
    logic [7:0]  d1;
    logic [7:0]  d2;
    logic [23:0] ev;
    if (b >= 8'hF8) begin
      // realtime: invisible
    end else if (b == 8'hF0) begin
      m_status = 8'h00; m_in_sysex = 1'b1; m_pend.delete();
    end else if (b >= 8'hF1) begin
      m_status = 8'h00; m_in_sysex = 1'b0; m_pend.delete();
    end else if (b >= 8'h80) begin
      m_status = b; m_in_sysex = 1'b0; m_pend.delete();
    end else if (m_in_sysex) begin
      // SysEx payload: silently discarded
    end else if (m_status == 8'h00) begin
      if (m_drops < 255) m_drops++;
    end else begin
      m_pend.push_back(b);
      need = ((m_status >> 4) == 8'hC || (m_status >> 4) == 8'hD) ? 1 : 2;
      if (m_pend.size() == need) begin
        d1 = m_pend[0];
        d2 = (need == 2) ? m_pend[1] : 8'h00;
        if ((m_status >> 4) == 8'h9 && d2 == 8'h00) ev = {8'h80, d1, 8'h00};
        else ev = {m_status & 8'hF0, d1, d2};
        exp_q0.push_back(ev);
        if ((m_status & 8'h0F) == 8'h00) exp_q1.push_back(ev);
        m_pend.delete();
      end
    end
  endtask

  // Scoreboard: compare everything the previous byte could have produced.
  task automatic check_outputs();
    bit ev0;
    bit ev1;
    ev0 = (exp_q0.size() != 0);
    ev1 = (exp_q1.size() != 0);
    check_val("valid_omni", {31'd0, bus_a.event_valid_out}, {31'd0, ev0});
    check_val("valid_filt", {31'd0, bus_f.event_valid_out}, {31'd0, ev1});
    if (ev0) m_last0 = exp_q0.pop_front();
    if (ev1) m_last1 = exp_q1.pop_front();
    check_val("event_omni", {8'd0, bus_a.midi_event_out}, {8'd0, m_last0});
    check_val("event_filt", {8'd0, bus_f.midi_event_out}, {8'd0, m_last1});
    check_val("drop_omni", {24'd0, bus_a.drop_count_out}, m_drops);
    check_val("drop_filt", {24'd0, bus_f.drop_count_out}, m_drops);
  endtask

  // Driver: one cycle per call, inputs change on the falling edge.
  task automatic tick(input logic v, input logic [7:0] b);
    @(negedge clk);
    check_outputs();
    bus_a.byte_in = b; bus_a.byte_valid_in = v;
    bus_f.byte_in = b; bus_f.byte_valid_in = v;
    if (v) model_byte(b);
  endtask

  task automatic send_seq();
    foreach (seq[i]) tick(1'b1, seq[i]);
    tick(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus_a.byte_valid_in = 1'b0; bus_f.byte_valid_in = 1'b0;
    bus_a.byte_in = 8'h00;      bus_f.byte_in = 8'h00;
    #2 rst = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    check_val("rst_event", {8'd0, bus_a.midi_event_out}, 32'd0);
    check_val("rst_valid", {31'd0, bus_a.event_valid_out}, 32'd0);
    check_val("rst_drop",  {24'd0, bus_a.drop_count_out}, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    int r;
    logic [7:0] b;
    rst = 1'b1;
    bus_a.byte_in = 8'h00; bus_a.byte_valid_in = 1'b0;
    bus_f.byte_in = 8'h00; bus_f.byte_valid_in = 1'b0;
    model_clear();
    do_reset();

    // Note on, then running status on channel 3 (filtered instance stays silent).
    seq = '{8'h90, 8'h3C, 8'h64}; send_seq();
    check_val("note_on", {8'd0, bus_a.midi_event_out}, 32'h00903C64);
    seq = '{8'h93, 8'h40, 8'h50, 8'h41, 8'h51}; send_seq();
    check_val("running", {8'd0, bus_a.midi_event_out}, 32'h00904151);
    check_val("filt_quiet", {8'd0, bus_f.midi_event_out}, 32'h00903C64);
    // Realtime between data bytes, velocity-zero normalisation.
    seq = '{8'h90, 8'h3C, 8'hF8, 8'h64}; send_seq();
    seq = '{8'h90, 8'h3C, 8'h00}; send_seq();
    check_val("vel0", {8'd0, bus_a.midi_event_out}, 32'h00803C00);
    // Two-byte messages, pitch bend, aborted partial message.
    seq = '{8'hC0, 8'h05, 8'h06}; send_seq();
    check_val("pgm", {8'd0, bus_a.midi_event_out}, 32'h00C00600);
    seq = '{8'hE0, 8'h00, 8'h40}; send_seq();
    check_val("bend", {8'd0, bus_a.midi_event_out}, 32'h00E00040);
    seq = '{8'hB1, 8'h07, 8'hB0, 8'h07, 8'h7F}; send_seq();
    check_val("abort", {8'd0, bus_a.midi_event_out}, 32'h00B0077F);
    // Identical back-to-back events still pulse.
    seq = '{8'h90, 8'h3C, 8'h64, 8'h3C, 8'h64}; send_seq();

    // SysEx skip then stray data after F7.
    do_reset();
    seq = '{8'hF0, 8'h7E, 8'h01, 8'hF7, 8'h3C}; send_seq();
    check_val("sysex_drop", {24'd0, bus_a.drop_count_out}, 32'd1);

    // Drop counter saturation.
    do_reset();
    for (int i = 0; i < 300; i++) tick(1'b1, 8'($urandom_range(0, 127)));
    tick(1'b0, 8'h00);
    check_val("drop_sat", {24'd0, bus_a.drop_count_out}, 32'd255);

    // Reset in the middle of a message.
    do_reset();
    seq = '{8'h90, 8'h3C}; send_seq();
    do_reset();
    seq = '{8'h40}; send_seq();
    check_val("mid_rst_drop", {24'd0, bus_a.drop_count_out}, 32'd1);
    check_val("mid_rst_event", {8'd0, bus_a.midi_event_out}, 32'd0);

    // Randomised stream with gaps.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 127));
      else if (r < 75) b = {4'($urandom_range(8, 14)), 4'($urandom_range(0, 2))};
      else if (r < 85) b = 8'($urandom_range(248, 255));
      else if (r < 90) b = 8'hF0;
      else if (r < 95) b = 8'hF7;
      else             b = 8'($urandom_range(241, 246));
      tick($urandom_range(0, 4) != 0, b);
    end
    tick(1'b0, 8'h00);
    tick(1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/midi_parser.md
Name: midi_parser

Overview:
- Converts the raw MIDI byte stream from the UART receiver into complete 3-byte channel-voice events for the downstream note/pitch decoder.
- Handles running status, realtime interleaving, SysEx and system-common skipping, and channel filtering.
- Normalises NOTE_ON with velocity 0 to NOTE_OFF.
- Holds the last complete event on a registered bus and strobes a valid pulse for each event.

Parameters:
- CHANNEL, 0, MIDI channel (0-15) accepted when OMNI=0.
- OMNI, 1, 1 = accept all channels; 0 = accept only CHANNEL.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-high
- byte_in  input  8  received MIDI byte
- byte_valid_in  input  1  byte_in valid this cycle (single-cycle strobe per byte)
- midi_event_out  output  MIDI_BYTES (24, constants package)  {status, data1, data2}; status channel nibble forced to 0
- event_valid_out  output  1  one-cycle pulse when midi_event_out is updated
- drop_count_out  output  8  saturating count of discarded data bytes

Behaviour:
- Reset (async assert, sync-released use): midi_event_out=0, event_valid_out=0, drop_count_out=0, running_status=0 (none), state=IDLE.
- Bytes are processed only when byte_valid_in=1; otherwise state is held and event_valid_out=0.
- Byte classes:
  - realtime F8-FF: ignored completely; no state, running-status or counter change, even when it falls between data bytes.
  - SysEx start F0: state=SYSEX; running status cleared.
  - system common F1-F7: running status cleared; state=IDLE. This includes F7 outside SysEx.
  - channel status 80-EF: latch running_status; state=WAIT_D1.
  - data 00-7F: handled per state.
- States:
  - IDLE: data byte -> dropped; drop_count_out += 1.
  - WAIT_D1: data byte -> latch d1.
    - 2-byte types (Cx program change, Dx channel pressure): emit {status, d1, 8'h00}; stay WAIT_D1 (running status).
    - All others: go WAIT_D2.
  - WAIT_D2: data byte -> emit {status, d1, d2}; return to WAIT_D1 (running status).
  - SYSEX: data bytes discarded without counting. Any status byte other than realtime leaves SYSEX and is then handled per its class; F7 -> IDLE.
- A channel status byte arriving in WAIT_D2 aborts the partial message: d1 is discarded and not counted, and the new status is latched.
- Channel filter: when OMNI=0 and status[3:0]!=CHANNEL, the message is parsed normally but not emitted. Those data bytes are not counted as drops.
- Emit:
  - On the cycle after the final data byte is accepted, midi_event_out = normalised event and event_valid_out=1 for exactly one cycle.
  - midi_event_out holds until the next emit.
  - Latency is 1 clock from the accepting edge.
- Normalisation:
  - Status is output as {status[7:4], 4'h0}.
  - 9x with data2==0 is emitted as {8'h80, d1, 8'h00}.
- Identical consecutive events still pulse event_valid_out. midi_event_out does not change in that case, so consumers that detect events by value change see only the first.
- drop_count_out saturates at 255 and never wraps.
- Back-to-back bytes on consecutive cycles must be supported at full rate, with no throughput loss.

Test Plan:
- Bytes 90 3C 64 -> one cycle after 64: midi_event_out=903C64, event_valid_out=1 for 1 cycle.
- 93 40 50 then running status 41 51 -> events 904050 then 904151, two pulses. With OMNI=0, CHANNEL=0: no events and drop_count_out stays 0.
- 90 3C F8 64 (clock tick interleaved) -> single event 903C64. 90 3C 00 -> event 803C00.
- C0 05 06 -> events C00500 then C00600. E0 00 40 -> E00040.
- F0 7E 01 F7 3C -> no events; drop_count_out=1 (3C after F7 hits IDLE). 300 stray data bytes from reset -> drop_count_out=255.
- Assert rst_in mid-message (after 90 3C), release, then 40 -> no event; drop_count_out=1; midi_event_out=0.
